// File: rtl/ifmap_window_buffer_if.sv
// ifmap_window_buffer_if: stream, window-control and selector-facing signals of the
// input-feature-map window buffer. The master drives writes and control; the slave
// (the buffer) returns readiness, selector index and entry contents.
// Optional macro IFMAP_WINDOW_BUFFER_WINCNT_EN adds the win_count status bus.
interface ifmap_window_buffer_if #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
);
  logic                   wr_valid;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_ready;
  logic                   start;
  logic [ADDR_W:0]        win_len;
  logic [ADDR_W:0]        stride;
  logic                   flush;
  logic                   rd_en;
  logic                   rd_valid;
  logic [ADDR_W-1:0]      rd_sel;
  logic                   win_done;
  logic [WIDTH*DEPTH-1:0] buf_flat;
  logic [ADDR_W:0]        count;
`ifdef IFMAP_WINDOW_BUFFER_WINCNT_EN
  logic [15:0]            win_count;

  modport master (
    output wr_valid, wr_data, start, win_len, stride, flush, rd_en,
    input  wr_ready, rd_valid, rd_sel, win_done, buf_flat, count, win_count
  );
  modport slave (
    input  wr_valid, wr_data, start, win_len, stride, flush, rd_en,
    output wr_ready, rd_valid, rd_sel, win_done, buf_flat, count, win_count
  );
`else
  modport master (
    output wr_valid, wr_data, start, win_len, stride, flush, rd_en,
    input  wr_ready, rd_valid, rd_sel, win_done, buf_flat, count
  );
  modport slave (
    input  wr_valid, wr_data, start, win_len, stride, flush, rd_en,
    output wr_ready, rd_valid, rd_sel, win_done, buf_flat, count
  );
`endif
endinterface

// File: rtl/ifmap_window_buffer.sv
// ifmap_window_buffer: circular byte buffer feeding a 16:1 selector. Bytes arrive on
// a valid/ready stream; once enough are held, the buffer walks a window of win_len
// entries through rd_sel, then slides the window start by stride and frees those slots.
// Optional macro IFMAP_WINDOW_BUFFER_WINCNT_EN adds a 16-bit completed-window counter.
module ifmap_window_buffer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  ifmap_window_buffer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_FILL, READ, SHIFT} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   win_len_q, win_len_d;
  logic [ADDR_W:0]   stride_q, stride_d;
  logic              win_done_q, win_done_d;
  logic              wr_acc;
  logic [ADDR_W:0]   freed;
`ifdef IFMAP_WINDOW_BUFFER_WINCNT_EN
  logic [15:0]       win_count_q, win_count_d;
`endif

  // Window length / slide of 0 means 1; anything beyond the buffer means the whole buffer.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] v);
    if (v == '0)         return ONE_C;
    else if (v > DEPTH_C) return DEPTH_C;
    else                  return v;
  endfunction

  // Next-state logic: window FSM, write acceptance, occupancy and flush override.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    head_d     = head_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    win_len_d  = win_len_q;
    stride_d   = stride_q;
    win_done_d = 1'b0;
    freed      = '0;
    wr_acc     = bus.wr_valid && (count_q < DEPTH_C) && !bus.flush;
`ifdef IFMAP_WINDOW_BUFFER_WINCNT_EN
    win_count_d = win_count_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          win_len_d = clamp_len(bus.win_len);
          stride_d  = clamp_len(bus.stride);
          state_d   = WAIT_FILL;
        end
      end
      WAIT_FILL: begin
        if (count_q >= win_len_q) begin
          rd_ptr_d = head_q;
          rd_cnt_d = '0;
          state_d  = READ;
        end
      end
      READ: begin
        if (bus.rd_en) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          rd_cnt_d = rd_cnt_q + ONE_C;
          if (rd_cnt_q == win_len_q - ONE_C) begin
            win_done_d = 1'b1;
            state_d    = SHIFT;
          end
        end
      end
      SHIFT: begin
        // Occupancy never drops below zero even if stride exceeds what is held.
        freed   = (stride_q < count_q) ? stride_q : count_q;
        head_d  = head_q + freed[ADDR_W-1:0];
        state_d = WAIT_FILL;
      end
      default: state_d = IDLE;
    endcase

    if (wr_acc) begin
      mem_d[wr_ptr_q] = bus.wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    count_d = count_q + {{ADDR_W{1'b0}}, wr_acc} - freed;

`ifdef IFMAP_WINDOW_BUFFER_WINCNT_EN
    if (win_done_d) win_count_d = win_count_q + 16'd1;
`endif

    // Flush empties the buffer but leaves entry contents in place.
    if (bus.flush) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      head_d     = '0;
      rd_ptr_d   = '0;
      rd_cnt_d   = '0;
      count_d    = '0;
      win_done_d = 1'b0;
`ifdef IFMAP_WINDOW_BUFFER_WINCNT_EN
      win_count_d = '0;
`endif
    end
  end

  // State and storage registers with synchronous reset that also clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      head_q     <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      count_q    <= '0;
      win_len_q  <= ONE_C;
      stride_q   <= ONE_C;
      win_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef IFMAP_WINDOW_BUFFER_WINCNT_EN
      win_count_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      head_q     <= head_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      count_q    <= count_d;
      win_len_q  <= win_len_d;
      stride_q   <= stride_d;
      win_done_q <= win_done_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef IFMAP_WINDOW_BUFFER_WINCNT_EN
      win_count_q <= win_count_d;
`endif
    end
  end

  // rd_sel is a register so the downstream selector path starts at a flop.
  assign bus.wr_ready = (count_q < DEPTH_C);
  assign bus.rd_valid = (state_q == READ);
  assign bus.rd_sel   = rd_ptr_q;
  assign bus.win_done = win_done_q;
  assign bus.count    = count_q;
`ifdef IFMAP_WINDOW_BUFFER_WINCNT_EN
  assign bus.win_count = win_count_q;
`endif

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
    assign bus.buf_flat[gi*WIDTH +: WIDTH] = mem_q[gi];
  end
endmodule

// File: tb/tb_ifmap_window_buffer.sv
// tb_ifmap_window_buffer: directed scenarios with random payload bytes, checked
// against a queue-style model (contents array, write index, window start, occupancy).
module tb_ifmap_window_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifmap_window_buffer_if #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) bus ();
  ifmap_window_buffer #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model of the buffer as seen from outside.
  logic [7:0] m_mem [16];
  int m_wr, m_head, m_count, m_len, m_stride;
  int errors = 0;
  int checks = 0;
  int win_no = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = m_mem[i];
    return f;
  endfunction

  function automatic int clampv(input int v);
    if (v == 0) return 1;
    if (v > 16) return 16;
    return v;
  endfunction

  task automatic m_flush();
    m_wr = 0; m_head = 0; m_count = 0;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    bit acc;
    acc = (m_count < 16);
    chk("wr_ready", bus.wr_ready, acc);
    bus.wr_valid = 1'b1; bus.wr_data = d;
    tick();
    bus.wr_valid = 1'b0;
    if (acc) begin
      m_mem[m_wr] = d; m_wr = (m_wr + 1) % 16; m_count++;
    end
    chk("count_after_write", bus.count, m_count);
  endtask

  task automatic do_start(input int len, input int str);
    bus.start = 1'b1; bus.win_len = 5'(len); bus.stride = 5'(str);
    tick();
    bus.start = 1'b0;
    m_len = clampv(len); m_stride = clampv(str);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    m_flush();
    chk("flush_count", bus.count, 0);
    chk("flush_rd_valid", bus.rd_valid, 0);
    chk("flush_keeps_entries", bus.buf_flat, m_flat());
  endtask

  // Walk one full window, then the slide cycle; optionally write during the slide.
  task automatic run_window(input bit wr_in_shift, input logic [7:0] sd);
    int n;
    int freed;
    bit acc;
    n = 0;
    while (!bus.rd_valid && n < 64) begin tick(); n++; end
    chk("rd_valid_wait", bus.rd_valid, 1);
    if (!bus.rd_valid) return;
    $display("window %0d head=%0d len=%0d stride=%0d count=%0d", win_no, m_head, m_len, m_stride, m_count);
    win_no++;
    for (int k = 0; k < m_len; k++) begin
      chk("rd_sel", bus.rd_sel, (m_head + k) % 16);
      chk("sel_byte", bus.buf_flat[bus.rd_sel*8 +: 8], m_mem[(m_head + k) % 16]);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
    chk("win_done_pulse", bus.win_done, 1);
    chk("rd_valid_in_shift", bus.rd_valid, 0);
    acc = wr_in_shift && (m_count < 16);
    bus.wr_valid = wr_in_shift; bus.wr_data = sd;
    tick();
    bus.wr_valid = 1'b0;
    freed = (m_stride < m_count) ? m_stride : m_count;
    m_head = (m_head + freed) % 16;
    if (acc) begin m_mem[m_wr] = sd; m_wr = (m_wr + 1) % 16; end
    m_count = m_count + (acc ? 1 : 0) - freed;
    chk("count_after_shift", bus.count, m_count);
    chk("win_done_clear", bus.win_done, 0);
  endtask

  initial begin
    int n;
    logic [127:0] snap;
    bus.wr_valid = 0; bus.wr_data = 0; bus.start = 0; bus.win_len = 0;
    bus.stride = 0; bus.flush = 0; bus.rd_en = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_flush(); m_len = 1; m_stride = 1;

    // Reset state
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_count", bus.count, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_sel", bus.rd_sel, 0);
    chk("rst_win_done", bus.win_done, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_entries", bus.buf_flat, 128'h0);

    // Fill 0x00..0x0F, then hold a write against a full buffer
    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    chk("full_wr_ready", bus.wr_ready, 0);
    snap = bus.buf_flat;
    wr_byte(8'($urandom));
    chk("full_no_change", bus.buf_flat, snap);

    // win_len=3, stride=1: windows 0,1,2 then 1,2,3
    do_start(3, 1);
    run_window(0, 8'h00);
    chk("count_15", bus.count, 15);
    run_window(0, 8'h00);
    do_flush();

    // stride=2 slide frees two slots that refill entries 0 and 1
    for (int i = 0; i < 16; i++) wr_byte(8'($urandom));
    do_start(2, 2);
    run_window(0, 8'h00);
    wr_byte(8'($urandom));
    wr_byte(8'($urandom));
    chk("refill_e0", bus.buf_flat[7:0], m_mem[0]);
    chk("refill_e1", bus.buf_flat[15:8], m_mem[1]);
    chk("refill_full", bus.count, 16);
    do_flush();

    // Wrap: slides of 7 bring the window start to 14 -> 14,15,0,1
    for (int i = 0; i < 16; i++) wr_byte(8'($urandom));
    do_start(4, 7);
    for (int w = 0; w < 3; w++) begin
      if (w == 2) chk("wrap_head", bus.rd_sel, 14);
      run_window(0, 8'h00);
      while (m_count < 16) wr_byte(8'($urandom));
    end
    do_flush();

    // Write accepted in the slide cycle: 10 + 1 - 3
    for (int i = 0; i < 10; i++) wr_byte(8'($urandom));
    do_start(2, 3);
    run_window(1, 8'($urandom));
    chk("shift_write_count", bus.count, 8);
    do_flush();

    // Starvation, then flush mid-window
    wr_byte(8'($urandom)); wr_byte(8'($urandom));
    do_start(5, 1);
    for (int i = 0; i < 3; i++) begin tick(); chk("starve_rd_valid", bus.rd_valid, 0); end
    for (int i = 0; i < 3; i++) wr_byte(8'($urandom));
    chk("starve_still_waiting", bus.rd_valid, 0);
    tick();
    chk("starve_released", bus.rd_valid, 1);
    chk("starve_rd_sel", bus.rd_sel, 0);
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    chk("mid_rd_sel", bus.rd_sel, 1);
    do_flush();
    chk("flush_no_win_done", bus.win_done, 0);
    tick();
    chk("flush_no_win_done_late", bus.win_done, 0);

    // Reset mid-window clears everything including entries
    for (int i = 0; i < 5; i++) wr_byte(8'($urandom));
    do_start(3, 1);
    n = 0;
    while (!bus.rd_valid && n < 64) begin tick(); n++; end
    chk("rst_case_read", bus.rd_valid, 1);
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_flush();
    chk("rstmid_rd_valid", bus.rd_valid, 0);
    chk("rstmid_count", bus.count, 0);
    chk("rstmid_win_done", bus.win_done, 0);
    chk("rstmid_entries", bus.buf_flat, 128'h0);
    chk("rstmid_rd_sel", bus.rd_sel, 0);

    // Clamping (0 -> 1, 20 -> 16) and start ignored outside IDLE
    for (int i = 0; i < 3; i++) wr_byte(8'($urandom));
    do_start(0, 20);
    run_window(0, 8'h00);
    chk("clamp_stride_empty", bus.count, 0);
    bus.start = 1'b1; bus.win_len = 5'd5; bus.stride = 5'd5;
    tick();
    bus.start = 1'b0;
    wr_byte(8'($urandom));
    run_window(0, 8'h00);
`ifdef IFMAP_WINDOW_BUFFER_WINCNT_EN
    chk("win_count", bus.win_count, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ifmap_window_buffer.md
Name: ifmap_window_buffer

Overview:
- Circular 16-entry byte buffer that sits directly upstream of the 16:1 byte selector in the CNN datapath.
- Accepts input-feature-map bytes over a valid/ready stream.
- Exposes all entries as a flat bus and drives the selector's 4-bit select. It walks a convolution window of win_len entries, then slides the window by stride entries and frees those slots for refill.

Parameters:
- WIDTH, 8, bits per entry.
- DEPTH, 16, number of entries; must be a power of 2.
- ADDR_W, 4, log2(DEPTH); width of pointers and of rd_sel.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_valid  in  1  upstream byte valid.
- wr_data  in  WIDTH  upstream byte.
- wr_ready  out  1  buffer can accept a byte.
- start  in  1  pulse; latches win_len/stride and begins window processing.
- win_len  in  ADDR_W+1  window length, 1..DEPTH.
- stride  in  ADDR_W+1  window slide, 1..DEPTH.
- flush  in  1  pulse; empties the buffer and returns to IDLE.
- rd_en  in  1  downstream consumed the current selected byte.
- rd_valid  out  1  rd_sel points at a valid window element.
- rd_sel  out  ADDR_W  physical entry index; drives the selector's sel.
- win_done  out  1  one-cycle pulse after the last element of a window is consumed.
- buf_flat  out  WIDTH*DEPTH  entry i at bits [i*WIDTH +: WIDTH].
- count  out  ADDR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; wr_ptr, head, rd_ptr, rd_cnt, count = 0; rd_valid=0, rd_sel=0, win_done=0; all entries = 0. Reset mid-operation aborts immediately; no partial window completes.
- Write side:
  - wr_ready = (count < DEPTH), combinational from registered count.
  - Accept when wr_valid & wr_ready: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1 mod DEPTH.
  - Writes are accepted in every state, IDLE included.
- count update per cycle: count_next = count + accepted_write − freed, where freed is nonzero only in SHIFT. A write and a free in the same cycle net correctly; count never exceeds DEPTH and never underflows.
- Latching at start: win_len_q and stride_q are latched on start in IDLE. Value 0 is treated as 1; values > DEPTH clamp to DEPTH. start outside IDLE is ignored.
- IDLE:
  - rd_valid=0.
  - start -> WAIT_FILL.
- WAIT_FILL:
  - rd_valid=0.
  - When count >= win_len_q: rd_ptr <= head, rd_cnt <= 0, go to READ.
  - The earliest transition is the same edge at which the condition is seen.
- READ:
  - rd_valid=1; rd_sel = rd_ptr (registered, so buf_flat plus the selector yields the byte combinationally).
  - On rd_en: rd_ptr <= rd_ptr+1 mod DEPTH, rd_cnt <= rd_cnt+1.
  - If rd_cnt == win_len_q−1 on rd_en: go to SHIFT and assert win_done for the next cycle.
  - rd_en while rd_valid=0 is ignored.
- SHIFT (exactly 1 cycle):
  - rd_valid=0.
  - freed = min(stride_q, count); head <= head+freed mod DEPTH.
  - Return to WAIT_FILL. Windows repeat until flush or rst.
- flush: highest priority below rst. Sets wr_ptr=head=rd_ptr=count=0 and state=IDLE, and drops rd_valid next cycle. Entry contents are retained, not cleared. A write in the same cycle as flush is dropped.
- Wrap-around: all pointers wrap modulo DEPTH. A window may straddle entry 15 -> 0.
- Entries between head and head+count−1 are never overwritten, because wr_ready gates writes.

Optional Feature:
- Macro: IFMAP_WINDOW_BUFFER_WINCNT_EN.
- Defined: adds output win_count [15:0].
  - Increments on every win_done and wraps at 0xFFFF -> 0.
  - Cleared by rst and by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Fill with bytes 0x00..0x0F (count=16, wr_ready=0), then start with win_len=3, stride=1:
  - rd_sel sequence is 0,1,2, then win_done.
  - Next window is 1,2,3; count drops to 15 after the SHIFT cycle.
- Backpressure: count=16 with wr_valid=1 -> wr_ready=0 and no entry changes. After one SHIFT with stride=2, two further writes land at entries 0 and 1.
- Wrap: head=14, win_len=4, 16 entries valid -> rd_sel sequence is 14,15,0,1.
- Simultaneous write during SHIFT: count=10, stride=3, write accepted in the SHIFT cycle -> count=8.
- Starvation: count=2, win_len=5 -> remains in WAIT_FILL with rd_valid=0; three writes -> rd_valid=1 on the cycle after count reaches 5.
- Flush mid-READ at rd_cnt=1 -> rd_valid=0 next cycle, count=0, no win_done. Separately, rst mid-READ gives the same result, and all entries read 0.
